// File: rtl/jtcps1_gfx_arb.sv
// Round-robin arbiter between the three CPS1 scroll tilemap GFX clients and one
// SDRAM read port; one transfer in flight, per-client data/ok held while the key is stable.
module jtcps1_gfx_arb #(
   parameter int AW       = 24,
   parameter int BANK_LSB = 20
) (
   input  logic          clk,
   input  logic          rst,

   input  logic [22:0]   rom1_addr,
   input  logic [3:0]    rom1_bank,
   input  logic          rom1_half,
   input  logic          rom1_cs,
   output logic [31:0]   rom1_data,
   output logic          rom1_ok,

   input  logic [22:0]   rom2_addr,
   input  logic [3:0]    rom2_bank,
   input  logic          rom2_half,
   input  logic          rom2_cs,
   output logic [31:0]   rom2_data,
   output logic          rom2_ok,

   input  logic [22:0]   rom3_addr,
   input  logic [3:0]    rom3_bank,
   input  logic          rom3_half,
   input  logic          rom3_cs,
   output logic [31:0]   rom3_data,
   output logic          rom3_ok,

   output logic [AW-1:0] sdram_addr,
   output logic          sdram_req,
   input  logic          sdram_ack,
   input  logic          sdram_rdy,
   input  logic [31:0]   sdram_din
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   localparam int KW = 28;

   logic [KW-1:0] key  [1:3];
   logic [AW-1:0] flat [1:3];
   logic [3:1]    cs;
   logic [3:1]    pend;

   state_t        state_q, state_d;
   logic [1:0]    g_q, g_d;
   logic [1:0]    last_gnt_q, last_gnt_d;
   logic [KW-1:0] lkey_q, lkey_d;
   logic [AW-1:0] sdram_addr_q, sdram_addr_d;
   logic          sdram_req_q, sdram_req_d;
   logic [KW-1:0] last_q [1:3];
   logic [KW-1:0] last_d [1:3];
   logic [31:0]   data_q [1:3];
   logic [31:0]   data_d [1:3];
   logic [3:1]    v_q, v_d;
   logic [3:1]    ok_q, ok_d;

   logic [1:0]    c1, c2, c3, sel;
   logic          done;

   function automatic logic [1:0] rr_next(input logic [1:0] c);
      return (c == 2'd3) ? 2'd1 : c + 2'd1;
   endfunction

   assign cs     = {rom3_cs, rom2_cs, rom1_cs};
   assign key[1] = {rom1_bank, rom1_addr, rom1_half};
   assign key[2] = {rom2_bank, rom2_addr, rom2_half};
   assign key[3] = {rom3_bank, rom3_addr, rom3_half};

   // Bank offset is added, not OR-ed, so a carry out of {addr,half} is simply dropped
   assign flat[1] = AW'({rom1_addr, rom1_half}) + (AW'(rom1_bank) << BANK_LSB);
   assign flat[2] = AW'({rom2_addr, rom2_half}) + (AW'(rom2_bank) << BANK_LSB);
   assign flat[3] = AW'({rom3_addr, rom3_half}) + (AW'(rom3_bank) << BANK_LSB);

   always_comb begin
      for (int unsigned i = 1; i <= 3; i++) begin
         pend[i] = cs[i] && (!v_q[i] || key[i] != last_q[i]);
      end
      c1 = rr_next(last_gnt_q);
      c2 = rr_next(c1);
      c3 = rr_next(c2);
      if (pend[c1])      sel = c1;
      else if (pend[c2]) sel = c2;
      else               sel = c3;
   end

   always_comb begin
      state_d      = state_q;
      g_d          = g_q;
      last_gnt_d   = last_gnt_q;
      lkey_d       = lkey_q;
      sdram_addr_d = sdram_addr_q;
      sdram_req_d  = sdram_req_q;
      done         = 1'b0;
      for (int unsigned i = 1; i <= 3; i++) begin
         last_d[i] = last_q[i];
         data_d[i] = data_q[i];
         ok_d[i]   = v_q[i] && cs[i] && (key[i] == last_q[i]);
         v_d[i]    = v_q[i] && cs[i];
      end

      case (state_q)
         IDLE: begin
            if (|pend) begin
               g_d         = sel;
               last_gnt_d  = sel;
               sdram_req_d = 1'b1;
               state_d     = REQ;
               for (int unsigned i = 1; i <= 3; i++) begin
                  if (sel == 2'(i)) begin
                     lkey_d       = key[i];
                     sdram_addr_d = flat[i];
                  end
               end
            end
         end
         REQ: begin
            // ack and rdy together count as ack followed immediately by rdy
            if (sdram_ack) begin
               sdram_req_d = 1'b0;
               if (sdram_rdy) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (sdram_rdy) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      for (int unsigned i = 1; i <= 3; i++) begin
         if (done && g_q == 2'(i) && cs[i] && key[i] == lkey_q) begin
            data_d[i] = sdram_din;
            last_d[i] = lkey_q;
            v_d[i]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         g_q          <= 2'd3;
         last_gnt_q   <= 2'd3;
         lkey_q       <= '0;
         sdram_addr_q <= '0;
         sdram_req_q  <= 1'b0;
         v_q          <= '0;
         ok_q         <= '0;
         for (int unsigned i = 1; i <= 3; i++) begin
            last_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         last_gnt_q   <= last_gnt_d;
         lkey_q       <= lkey_d;
         sdram_addr_q <= sdram_addr_d;
         sdram_req_q  <= sdram_req_d;
         v_q          <= v_d;
         ok_q         <= ok_d;
         for (int unsigned i = 1; i <= 3; i++) begin
            last_q[i] <= last_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign sdram_addr = sdram_addr_q;
   assign sdram_req  = sdram_req_q;
   assign rom1_data  = data_q[1];
   assign rom2_data  = data_q[2];
   assign rom3_data  = data_q[3];
   assign rom1_ok    = ok_q[1];
   assign rom2_ok    = ok_q[2];
   assign rom3_ok    = ok_q[3];

endmodule

// File: tb/tb_jtcps1_gfx_arb.sv
// Bench for jtcps1_gfx_arb: directed scenarios with literal expectations, then
// random client/SDRAM traffic, all checked every cycle against a transaction-level model.
module tb_jtcps1_gfx_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [22:0] c_addr [1:3];
   logic [3:0]  c_bank [1:3];
   logic        c_half [1:3];
   logic        c_cs   [1:3];
   logic        ack, rdy;
   logic [31:0] din;

   logic [31:0] rom1_data, rom2_data, rom3_data;
   logic        rom1_ok, rom2_ok, rom3_ok;
   logic [23:0] sdram_addr;
   logic        sdram_req;

   int n_tests = 0;
   int n_fail  = 0;

   jtcps1_gfx_arb #(.AW(24), .BANK_LSB(20)) dut (
      .clk(clk), .rst(rst),
      .rom1_addr(c_addr[1]), .rom1_bank(c_bank[1]), .rom1_half(c_half[1]), .rom1_cs(c_cs[1]),
      .rom1_data(rom1_data), .rom1_ok(rom1_ok),
      .rom2_addr(c_addr[2]), .rom2_bank(c_bank[2]), .rom2_half(c_half[2]), .rom2_cs(c_cs[2]),
      .rom2_data(rom2_data), .rom2_ok(rom2_ok),
      .rom3_addr(c_addr[3]), .rom3_bank(c_bank[3]), .rom3_half(c_half[3]), .rom3_cs(c_cs[3]),
      .rom3_data(rom3_data), .rom3_ok(rom3_ok),
      .sdram_addr(sdram_addr), .sdram_req(sdram_req),
      .sdram_ack(ack), .sdram_rdy(rdy), .sdram_din(din)
   );

   // Reference model: one outstanding transaction record plus per-client cache lines
   logic [27:0] m_last [1:3];
   bit          m_v    [1:3];
   logic [31:0] m_data [1:3];
   bit          m_ok   [1:3];
   int          m_rr;
   bit          tx_active, tx_acked;
   int          tx_client;
   logic [27:0] tx_key;
   logic [23:0] m_addr;
   bit          m_req;

   function automatic logic [27:0] key_of(int i);
      return {c_bank[i], c_addr[i], c_half[i]};
   endfunction

   function automatic logic [23:0] flat_of(int i);
      longint f;
      f = longint'(c_bank[i]) * 1048576 + longint'(c_addr[i]) * 2 + longint'(c_half[i]);
      return 24'(f % 16777216);
   endfunction

   function automatic bit pending(int i);
      return c_cs[i] && (!m_v[i] || key_of(i) != m_last[i]);
   endfunction

   task automatic model_reset();
      for (int i = 1; i <= 3; i++) begin
         m_last[i] = '0; m_v[i] = 0; m_data[i] = '0; m_ok[i] = 0;
      end
      m_rr = 3; tx_active = 0; tx_acked = 0; tx_client = 0;
      tx_key = '0; m_addr = '0; m_req = 0;
   endtask

   task automatic model_step();
      bit ok_n [1:3];
      bit v_n  [1:3];
      bit fin;
      bit found;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 1; i <= 3; i++) begin
         ok_n[i] = m_v[i] && c_cs[i] && (key_of(i) == m_last[i]);
         v_n[i]  = m_v[i] && c_cs[i];
      end
      fin = 0;
      if (!tx_active) begin
         found = 0;
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_rr + k - 1) % 3 + 1;
            if (!found && pending(c)) begin
               found = 1;
               tx_active = 1; tx_acked = 0; tx_client = c;
               tx_key = key_of(c); m_addr = flat_of(c); m_req = 1; m_rr = c;
            end
         end
      end else if (!tx_acked) begin
         if (ack) begin
            m_req = 0; tx_acked = 1;
            if (rdy) fin = 1;
         end
      end else if (rdy) begin
         fin = 1;
      end
      if (fin) begin
         tx_active = 0; tx_acked = 0;
         if (c_cs[tx_client] && key_of(tx_client) == tx_key) begin
            m_data[tx_client] = din;
            m_last[tx_client] = tx_key;
            v_n[tx_client]    = 1;
         end
      end
      for (int i = 1; i <= 3; i++) begin
         m_v[i] = v_n[i]; m_ok[i] = ok_n[i];
      end
   endtask

   function automatic logic [31:0] dut_data(int i);
      case (i)
         1: return rom1_data;
         2: return rom2_data;
         default: return rom3_data;
      endcase
   endfunction

   function automatic logic dut_ok(int i);
      case (i)
         1: return rom1_ok;
         2: return rom2_ok;
         default: return rom3_ok;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("req", 32'(sdram_req), 32'(m_req));
      check("addr", 32'(sdram_addr), 32'(m_addr));
      for (int i = 1; i <= 3; i++) begin
         check($sformatf("data%0d", i), dut_data(i), m_data[i]);
         check($sformatf("ok%0d", i), 32'(dut_ok(i)), 32'(m_ok[i]));
      end
   endtask

   // One clock: model advances on the edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic serve(bit same, logic [31:0] d);
      if (same) begin
         ack = 1; rdy = 1; din = d;
         cycle();
         ack = 0; rdy = 0;
      end else begin
         ack = 1;
         cycle();
         ack = 0; rdy = 1; din = d;
         cycle();
         rdy = 0;
      end
   endtask

   task automatic new_key(int i);
      case ($urandom_range(0, 3))
         0: c_addr[i] = 23'h000000;
         1: c_addr[i] = 23'h7FFFFF;
         2: c_addr[i] = 23'h123456;
         default: c_addr[i] = 23'($urandom_range(0, 7));
      endcase
      c_bank[i] = 4'($urandom_range(0, 15));
      c_half[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      rst = 1; ack = 0; rdy = 0; din = '0;
      for (int i = 1; i <= 3; i++) begin
         c_addr[i] = '0; c_bank[i] = '0; c_half[i] = 0; c_cs[i] = 0;
      end
      model_reset();
      #1;
      compare_all();
      check("rst_req", 32'(sdram_req), 32'd0);
      check("rst_addr", 32'(sdram_addr), 32'd0);
      repeat (2) cycle();
      rst = 0;

      // Single client: flat address, first-word latency, ok held without re-request
      c_addr[1] = 23'h000010; c_bank[1] = 4'd2; c_half[1] = 1; c_cs[1] = 1;
      cycle();
      check("single_req", 32'(sdram_req), 32'd1);
      check("single_addr", 32'(sdram_addr), 32'h200021);
      check("model_addr", 32'(m_addr), 32'h200021);
      ack = 1; cycle(); ack = 0;
      check("single_req_drop", 32'(sdram_req), 32'd0);
      rdy = 1; din = 32'hDEADBEEF; cycle(); rdy = 0;
      check("single_data", rom1_data, 32'hDEADBEEF);
      check("single_ok_early", 32'(rom1_ok), 32'd0);
      cycle();
      check("single_ok", 32'(rom1_ok), 32'd1);
      repeat (4) cycle();
      check("single_no_rereq", 32'(sdram_req), 32'd0);
      check("single_ok_held", 32'(rom1_ok), 32'd1);
      c_cs[1] = 0; cycle();
      check("single_ok_cs_low", 32'(rom1_ok), 32'd0);

      // Round robin from reset: 1,2,3 then wrap to 1
      rst = 1; model_reset(); cycle(); rst = 0;
      c_addr[1] = 23'h100; c_addr[2] = 23'h200; c_addr[3] = 23'h300;
      for (int i = 1; i <= 3; i++) begin
         c_bank[i] = 0; c_half[i] = 0; c_cs[i] = 1;
      end
      cycle();
      check("rr_g1", 32'(sdram_addr), 32'h000200);
      serve(0, 32'hAAAA0001);
      check("rr_d1", rom1_data, 32'hAAAA0001);
      cycle();
      check("rr_g2", 32'(sdram_addr), 32'h000400);
      check("rr_ok1", 32'(rom1_ok), 32'd1);
      serve(1, 32'hBBBB0002);
      check("ackrdy_d2", rom2_data, 32'hBBBB0002);
      cycle();
      check("rr_g3", 32'(sdram_addr), 32'h000600);
      check("ackrdy_ok2", 32'(rom2_ok), 32'd1);
      serve(0, 32'hCCCC0003);
      cycle();
      check("rr_ok3", 32'(rom3_ok), 32'd1);
      check("rr_idle", 32'(sdram_req), 32'd0);

      // Key change on 1 and 2: ok drops next edge, grant wraps 3 -> 1
      c_addr[1] = 23'h180; c_addr[2] = 23'h280;
      cycle();
      check("kc_ok2_drop", 32'(rom2_ok), 32'd0);
      check("kc_req", 32'(sdram_req), 32'd1);
      check("rr_wrap_g1", 32'(sdram_addr), 32'h000300);
      serve(1, 32'h11110001);
      cycle();
      check("kc_g2", 32'(sdram_addr), 32'h000500);
      serve(0, 32'h22220002);
      cycle();
      check("kc_ok2", 32'(rom2_ok), 32'd1);
      check("kc_d2", rom2_data, 32'h22220002);

      // Address overflow then abandoned transfer on client 3
      c_addr[3] = 23'h7FFFFF; c_bank[3] = 4'hF; c_half[3] = 1;
      cycle();
      check("ovf_addr", 32'(sdram_addr), 32'hEFFFFF);
      check("ovf_ok3", 32'(rom3_ok), 32'd0);
      ack = 1; cycle(); ack = 0;
      c_cs[3] = 0; rdy = 1; din = 32'h12345678; cycle(); rdy = 0;
      check("abandon_d3", rom3_data, 32'hCCCC0003);
      check("abandon_ok3", 32'(rom3_ok), 32'd0);
      cycle();
      check("abandon_idle", 32'(sdram_req), 32'd0);
      c_cs[3] = 1; cycle();
      check("regrant_req", 32'(sdram_req), 32'd1);
      check("regrant_addr", 32'(sdram_addr), 32'hEFFFFF);
      c_cs[3] = 0; cycle();
      check("cs_drop_req_held", 32'(sdram_req), 32'd1);
      ack = 1; rdy = 1; din = 32'h55555555; cycle(); ack = 0; rdy = 0;
      check("cs_drop_d3", rom3_data, 32'hCCCC0003);
      cycle();
      check("cs_drop_ok3", 32'(rom3_ok), 32'd0);

      // Async reset while waiting for rdy; later rdy is ignored
      c_addr[1] = 23'h1C0; cycle();
      check("wr_addr", 32'(sdram_addr), 32'h000380);
      ack = 1; cycle(); ack = 0;
      #2 rst = 1;
      model_reset();
      #1;
      check("arst_req", 32'(sdram_req), 32'd0);
      check("arst_addr", 32'(sdram_addr), 32'd0);
      check("arst_d1", rom1_data, 32'd0);
      check("arst_ok1", 32'(rom1_ok), 32'd0);
      cycle();
      rst = 0;
      for (int i = 1; i <= 3; i++) c_cs[i] = 0;
      rdy = 1; din = 32'hFFFF0000; cycle(); rdy = 0;
      cycle();
      check("arst_rdy_d1", rom1_data, 32'd0);
      check("arst_rdy_ok1", 32'(rom1_ok), 32'd0);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         for (int i = 1; i <= 3; i++) begin
            if (!c_cs[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  c_cs[i] = 1; new_key(i);
               end
            end else if (m_ok[i]) begin
               case ($urandom_range(0, 7))
                  0: c_cs[i] = 0;
                  1: new_key(i);
                  default: ;
               endcase
            end else if ($urandom_range(0, 39) == 0) begin
               if ($urandom_range(0, 1) == 0) c_cs[i] = 0;
               else new_key(i);
            end
         end
         ack = 0; rdy = 0; din = $urandom;
         if (tx_active && !tx_acked) begin
            ack = ($urandom_range(0, 1) == 1);
            rdy = ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         end else if (tx_active) begin
            rdy = ($urandom_range(0, 2) == 0);
         end else begin
            rdy = ($urandom_range(0, 19) == 0);
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jtcps1_gfx_arb.md
# jtcps1_gfx_arb

Arbiter between the three scroll tilemap GFX ROM clients of the CPS1 video stage and the single SDRAM read port that holds the graphics ROM. Each client presents a tile-row address with bank offset and half select, holds its chip select, and waits for `ok`. The block forms the flat SDRAM word address, grants clients in round-robin order, and returns 32-bit data with a per-client `ok` that stays valid while the client keeps the same address.

## Interface
Parameters:
- `AW`, 24, SDRAM word address width
- `BANK_LSB`, 20, bit position at which the 4-bit bank offset is added

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `romN_addr` (N=1..3)  in  23  client tile-row address
- `romN_bank`  in  4  client bank offset from the GFX bank decoder
- `romN_half`  in  1  client half select, address LSB
- `romN_cs`  in  1  client request, held until `romN_ok`
- `romN_data`  out  32  data for client N, registered
- `romN_ok`  out  1  `romN_data` valid for the current client key
- `sdram_addr`  out  AW  word address, registered, stable while `sdram_req` is high
- `sdram_req`  out  1  read request, level, held until `sdram_ack`
- `sdram_ack`  in  1  one-cycle pulse, request accepted
- `sdram_rdy`  in  1  one-cycle pulse, `sdram_din` valid
- `sdram_din`  in  32  read data

## Operation
- Client key: `{bank, addr, half}`. Flat address = (`bank` << BANK_LSB) + {`addr`, `half`}, truncated modulo 2^AW; carry is discarded, no saturation.
- Per client: key register `lastN`, valid flag `vN`. Pending when `cs` is high and (`!vN` or the current key differs from `lastN`).
- `romN_ok` = `vN` and `cs` and (current key == `lastN`), registered. A key change or `cs` low drops `ok` on the next edge. `vN` is cleared when `cs` is low.
- Round-robin pointer `last_gnt` (1..3, reset 3). Grant order starts at `last_gnt`+1 and wraps 3→1. `last_gnt` is updated on each grant.
- FSM:
  - IDLE: if any client is pending, latch grant `g`, its key, and its address into `sdram_addr`; set `sdram_req`; go to REQ.
  - REQ: hold `sdram_req` and `sdram_addr`. On `sdram_ack`, clear `sdram_req` and go to WAIT.
  - WAIT: on `sdram_rdy`, go to IDLE.
    - If client `g` still has `cs` high and its key equals the latched key, write `romg_data` = `sdram_din`, set `lastg` = key and `vg` = 1.
    - Otherwise discard the data. The client becomes pending again and is re-arbitrated.
- `sdram_ack` and `sdram_rdy` in the same cycle while in REQ: treat as ack followed by rdy and complete the transfer in that cycle.
- `sdram_rdy` outside WAIT: ignored.
- Client `cs` dropping during REQ: the request is not withdrawn. It completes and the data is discarded.
- `romN_data` of non-granted clients never changes.

## Timing
- Reset values: `sdram_req`=0, `sdram_addr`=0, all `romN_ok`=0, all `romN_data`=0, all `vN`=0, FSM=IDLE, `last_gnt`=3.
- Reset asserted mid-transfer: everything returns to reset values immediately. A later `sdram_rdy` is ignored because the FSM is in IDLE.
- Pending seen in IDLE at edge k: `sdram_req`/`sdram_addr` high/valid after edge k.
- `sdram_ack` sampled at edge m: `sdram_req` low after m.
- `sdram_rdy` sampled at edge r: data and `vN` update at r; `romN_ok` high after edge r+1.
- FSM back in IDLE after r, so the next grant can issue at edge r+1. One transfer at a time, no pipelining.
- Minimum cs→ok latency with ack on the first REQ cycle and rdy one cycle later: 4 cycles.

## Test plan
- Single client: rom1 cs=1, addr=0x000010, bank=2, half=1 → `sdram_addr`=0x200021; rdy with din=0xDEADBEEF → `rom1_data`=0xDEADBEEF, `rom1_ok`=1 one cycle later. `ok` stays 1 with no second request while the key is held.
- Round robin: all three cs high from reset → grants in order 1,2,3,1. `last_gnt` wraps correctly.
- Key change: rom2 `ok`=1, then addr changes → `rom2_ok`=0 next cycle and a new `sdram_req` is issued with the new address.
- Abandoned request: rom3 drops cs during WAIT, rdy din=0x12345678 → `rom3_data` unchanged, `rom3_ok`=0, FSM in IDLE.
- Same-cycle ack+rdy in REQ → transfer completes and `ok` rises next cycle. Address overflow case: bank=0xF, addr=0x7FFFFF, half=1 → `sdram_addr`=0xEFFFFF, which is 0xF00000 + 0xFFFFFF modulo 2^24.
- Async reset asserted during WAIT, then rdy pulse → outputs at reset values and no `ok` rises.
